accum_32_unsigned: RTL
======================

ACCUM_32_UNSIGNED -- requirements
Module: accum_32_unsigned

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width.
REQ-002 SHALL have parameter CNT_W, default 8, beat-counter width.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat.
REQ-007 SHALL have port in_data  input  WIDTH  unsigned operand.
REQ-008 SHALL have port in_last  input  1  final beat of burst.
REQ-009 SHALL have port out_valid  output  1  burst result valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_sum  output  WIDTH  accumulated sum.
REQ-012 SHALL have port out_carry  output  1  sticky carry-out of any add in burst.
REQ-013 SHALL have port out_count  output  CNT_W  beats accepted in burst.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, HOLD; beat accepted when in_valid & in_ready.
REQ-015 SHALL drive in_ready=1 in IDLE and ACC, 0 in HOLD; out_valid=1 only in HOLD.
REQ-016 IDLE, accepted beat: acc<=in_data, carry<=0, count<=1; next ACC, or HOLD if in_last.
REQ-017 ACC, accepted beat: {c,acc}<=acc+in_data (WIDTH+1-bit), carry<=carry|c, count<=count+1; next HOLD if in_last, else stay ACC.
REQ-018 ACC without accepted beat: hold all state.
REQ-019 count SHALL saturate at 2^CNT_W-1, never wrap.
REQ-020 HOLD: out_sum/out_carry/out_count stable until out_ready; on out_valid&out_ready return to IDLE, next beat accepted no earlier than following cycle.
REQ-021 Latency: result visible (out_valid=1) the cycle after the in_last beat is accepted.
REQ-022 Single-beat burst (in_last in IDLE): out_sum=in_data, out_carry=0, out_count=1.
REQ-023 in_data/in_last SHALL be ignored when no beat is accepted.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, acc=0, carry=0, count=0, out_valid=0, in_ready=0 while asserted.
REQ-025 Reset mid-burst or in HOLD SHALL discard partial/unread result; in_ready=1 the first cycle after release.

Configuration
REQ-026 Macro ACCUM_SAT_EN defined: on any carry-out acc SHALL clamp to all-ones and remain all-ones for the rest of the burst; out_carry still set.
REQ-027 Macro ACCUM_SAT_EN undefined: acc SHALL wrap modulo 2^WIDTH; out_carry sticky.

Structure
REQ-028 Shared package accum_pkg SHALL hold FSM state enum (IDLE, ACC, HOLD) and default WIDTH/CNT_W constants.
REQ-029 Addition SHALL be done in one sub-module add32_ripple (combinational, a,b,cin -> sum, cout via full-adder equations), cin tied 0.

Verification
REQ-030 Beats 5,7,9 (last on 9), out_ready=1 -> out_sum=21, out_carry=0, out_count=3, out_valid one cycle after last.
REQ-031 Beats 0xFFFFFFFF, 0x2 (last) -> wrap build: out_sum=0x00000001, out_carry=1; ACCUM_SAT_EN build: out_sum=0xFFFFFFFF, out_carry=1.
REQ-032 Single beat 0x1234 with in_last -> out_sum=0x1234, out_count=1, out_carry=0.
REQ-033 Result in HOLD, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, extra beats not absorbed; out_ready=1 -> IDLE next cycle.
REQ-034 300 beats of 1 -> out_count=255 (saturated), out_sum=300.
REQ-035 rst_n pulsed low after 2 beats of burst -> outputs zero, IDLE; new burst 3,4 (last) -> out_sum=7, out_count=2.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared definitions for the unsigned burst accumulator: FSM state encoding
// and the default operand/sum and beat-counter widths.
package accum_pkg;

    localparam int ACC_WIDTH = 32;
    localparam int ACC_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/add32_ripple.sv
// Combinational ripple-carry adder built from per-bit full-adder equations.
module add32_ripple #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/accum_32_unsigned.sv
// Unsigned burst accumulator: sums a valid/ready burst, presents the result until taken.
// Define ACCUM_SAT_EN to clamp the sum to all-ones on overflow instead of wrapping.
module accum_32_unsigned
    import accum_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int CNT_W = ACC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             accept;

    add32_ripple #(.WIDTH(WIDTH)) u_add (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Ready is masked by reset so nothing is offered while the block is held in reset.
    assign in_ready  = rst_n & (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid & in_ready;

    assign out_sum   = acc_q;
    assign out_carry = carry_q;
    assign out_count = count_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = in_data;
                    carry_d = 1'b0;
                    count_d = CNT_W'(1);
                    state_d = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    carry_d = carry_q | add_cout;
`ifdef ACCUM_SAT_EN
                    acc_d   = (carry_q | add_cout) ? '1 : add_sum;
`else
                    acc_d   = add_sum;
`endif
                    count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
                    state_d = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

endmodule
